pdm_mic_emulator: RTL and testbench

//  Synthesizable PDM microphone model: the transmit end of the PDM link consumed by the mic interface.

---
 rtl/pdm_mic_emulator.sv | 149 ++++++++++++++
 tb/tb_pdm_mic_emulator.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pdm_mic_emulator.sv
// pdm_mic_emulator: PCM-in, second-order delta-sigma PDM-out microphone model for a shared stereo line
module pdm_mic_emulator #(
   parameter int DATA_W      = 16,
   parameter int OSR_W       = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                        ipg_clk,
   input  logic                        ipg_hard_async_reset_b,
   input  logic                        enable,
   input  logic                        lr_sel,
   input  logic [OSR_W-1:0]            osr,
   input  logic [DATA_W-1:0]           pcm_data,
   input  logic                        pcm_valid,
   output logic                        pcm_ready,
   input  logic                        pdm_clk,
   output logic                        pdm_data,
   output logic                        pdm_data_oe,
   output logic                        underflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int I_W   = DATA_W + 4;
   localparam int S_W   = I_W + 2;
   localparam logic signed [S_W-1:0] FS      = S_W'(2 ** (DATA_W - 1));
   localparam logic signed [S_W-1:0] SAT_MAX = S_W'(2 ** (I_W - 1) - 1);
   localparam logic signed [S_W-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

   state_t                   state_q, state_d;
   logic [SYNC_STAGES:0]     sync_q, sync_d;
   logic [DATA_W-1:0]        mem_q [FIFO_DEPTH];
   logic [DATA_W-1:0]        mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_q, wr_d, rd_q, rd_d;
   logic [LVL_W-1:0]         lvl_q, lvl_d;
   logic signed [DATA_W-1:0] cur_q, cur_d;
   logic [OSR_W-1:0]         cnt_q, cnt_d, osr_m1;
   logic signed [I_W-1:0]    i1_q, i1_d, i2_q, i2_d, i1_n, i2_n;
   logic signed [S_W-1:0]    fb;
   logic                     pdm_data_q, pdm_data_d, oe_q, oe_d, uf_q, uf_d;
   logic                     rise, fall, upd, rel, push, pop, flush, empty, due;

   function automatic logic signed [I_W-1:0] sat(input logic signed [S_W-1:0] v);
      return (v > SAT_MAX) ? I_W'(SAT_MAX) : (v < SAT_MIN) ? I_W'(SAT_MIN) : I_W'(v);
   endfunction

   // Edge detect on the synchronised bit clock, FIFO bookkeeping, modulator and state sequencing
   always_comb begin
      sync_d     = {sync_q[SYNC_STAGES-1:0], pdm_clk};
      rise       = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
      fall       = ~sync_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES];
      upd        = lr_sel ? rise : fall;
      rel        = lr_sel ? fall : rise;
      empty      = lvl_q == '0;
      pcm_ready  = lvl_q != LVL_W'(FIFO_DEPTH);
      push       = pcm_valid & pcm_ready;
      osr_m1     = (osr == '0) ? '0 : osr - 1'b1;
      due        = cnt_q >= osr_m1;
      fb         = pdm_data_q ? FS : -FS;
      i1_n       = sat(S_W'(i1_q) + S_W'(cur_q) - fb);
      i2_n       = sat(S_W'(i2_q) + S_W'(i1_n) - fb);
      state_d    = state_q;
      cur_d      = cur_q;
      cnt_d      = cnt_q;
      i1_d       = i1_q;
      i2_d       = i2_q;
      pdm_data_d = pdm_data_q;
      oe_d       = oe_q;
      uf_d       = uf_q;
      pop        = 1'b0;
      flush      = 1'b0;
      if (!enable) begin
         state_d    = IDLE;
         flush      = state_q != IDLE;
         cur_d      = '0;
         cnt_d      = '0;
         i1_d       = '0;
         i2_d       = '0;
         pdm_data_d = 1'b0;
         oe_d       = 1'b0;
         uf_d       = 1'b0;
      end else if (state_q == IDLE) begin
         state_d = PRIME;
      end else if (state_q == PRIME) begin
         if (upd && !empty) begin
            pop     = 1'b1;
            cur_d   = mem_q[rd_q];
            cnt_d   = '0;
            state_d = RUN;
         end
      end else if (upd) begin
         i1_d       = i1_n;
         i2_d       = i2_n;
         pdm_data_d = ~i2_n[I_W-1];
         oe_d       = 1'b1;
         cnt_d      = due ? '0 : cnt_q + 1'b1;
         pop        = due & ~empty;
         cur_d      = (due && !empty) ? mem_q[rd_q] : cur_q;
         uf_d       = uf_q | (due & empty);
      end else if (rel) begin
         oe_d = 1'b0;
      end
      lvl_d = flush ? '0 : lvl_q + LVL_W'(push) - LVL_W'(pop);
      wr_d  = flush ? '0 : wr_q + PTR_W'(push);
      rd_d  = flush ? '0 : rd_q + PTR_W'(pop);
      mem_d = mem_q;
      if (push) mem_d[wr_q] = pcm_data;
   end

   // All state registers; reset drops the line and empties the FIFO immediately
   always_ff @(posedge ipg_clk or negedge ipg_hard_async_reset_b) begin
      if (!ipg_hard_async_reset_b) begin
         state_q    <= IDLE;
         sync_q     <= '0;
         mem_q      <= '{default: '0};
         wr_q       <= '0;
         rd_q       <= '0;
         lvl_q      <= '0;
         cur_q      <= '0;
         cnt_q      <= '0;
         i1_q       <= '0;
         i2_q       <= '0;
         pdm_data_q <= 1'b0;
         oe_q       <= 1'b0;
         uf_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync_q     <= sync_d;
         mem_q      <= mem_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         lvl_q      <= lvl_d;
         cur_q      <= cur_d;
         cnt_q      <= cnt_d;
         i1_q       <= i1_d;
         i2_q       <= i2_d;
         pdm_data_q <= pdm_data_d;
         oe_q       <= oe_d;
         uf_q       <= uf_d;
      end
   end

   assign pdm_data    = pdm_data_q;
   assign pdm_data_oe = oe_q;
   assign underflow   = uf_q;
   assign fifo_level  = lvl_q;
endmodule

// File: tb/tb_pdm_mic_emulator.sv
// tb_pdm_mic_emulator: directed scoreboard bench for the PDM microphone model
module tb_pdm_mic_emulator;
   localparam int     FS   = 32768;
   localparam longint IMAX = (64'sd1 <<< 19) - 1;

   logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, lr_sel = 1'b0, pcm_valid = 1'b0, pdm_clk = 1'b1;
   logic [7:0]  osr = 8'd64;
   logic [15:0] pcm_data = '0;
   logic        pcm_ready, pdm_data, pdm_data_oe, underflow;
   logic [2:0]  fifo_level;

   int n_cmp = 0, n_bad = 0;

   int      m_state, m_cnt;
   longint  m_i1, m_i2;
   bit      m_prev, m_oe, m_uf;
   shortint m_cur;
   shortint m_fifo[$];
   bit      exp_q[$];
   int      ones, run_len, max_run, feed_left;
   bit      last_obs;
   shortint feed_val;

   pdm_mic_emulator dut (
      .ipg_clk(clk), .ipg_hard_async_reset_b(rst_n), .enable(enable), .lr_sel(lr_sel), .osr(osr),
      .pcm_data(pcm_data), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .pdm_clk(pdm_clk),
      .pdm_data(pdm_data), .pdm_data_oe(pdm_data_oe), .underflow(underflow), .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic longint clamp(input longint v);
      return (v > IMAX) ? IMAX : (v < -IMAX - 1) ? -IMAX - 1 : v;
   endfunction

   task automatic m_clear();
      m_state = 0; m_cnt = 0; m_i1 = 0; m_i2 = 0;
      m_prev = 0; m_oe = 0; m_uf = 0; m_cur = 0;
      m_fifo.delete();
      exp_q.delete();
   endtask

   task automatic m_upd();
      longint fb;
      int eff;
      if (m_state == 1 && m_fifo.size() > 0) begin
         m_cur = m_fifo.pop_front();
         m_cnt = 0;
         m_state = 2;
      end else if (m_state == 2) begin
         fb = m_prev ? FS : -FS;
         m_i1 = clamp(m_i1 + m_cur - fb);
         m_i2 = clamp(m_i2 + m_i1 - fb);
         m_prev = (m_i2 >= 0);
         m_oe = 1'b1;
         exp_q.push_back(m_prev);
         eff = (osr == 0) ? 1 : int'(osr);
         if (m_cnt >= eff - 1) begin
            m_cnt = 0;
            if (m_fifo.size() > 0) m_cur = m_fifo.pop_front();
            else m_uf = 1'b1;
         end else m_cnt++;
      end
   endtask

   task automatic push_one(input shortint v, output bit acc);
      pcm_data = v;
      pcm_valid = 1'b1;
      acc = pcm_ready;
      @(negedge clk);
      pcm_valid = 1'b0;
      if (acc) m_fifo.push_back(v);
   endtask

   task automatic upd_half();
      logic obs;
      pdm_clk = lr_sel;
      m_upd();
      repeat (2) @(negedge clk);
      chk("oe_before_upd", pdm_data_oe, 0);
      @(negedge clk);
      chk("oe_after_upd", pdm_data_oe, m_oe);
      if (exp_q.size() > 0) begin
         obs = pdm_data;
         chk("pdm_bit", obs, exp_q.pop_front());
         ones += int'(obs);
         run_len = (obs == last_obs) ? run_len + 1 : 1;
         last_obs = obs;
         if (run_len > max_run) max_run = run_len;
      end else chk("pdm_idle_bit", pdm_data, m_prev);
      @(negedge clk);
   endtask

   task automatic rel_half(input bit feed);
      bit was_oe, acc;
      was_oe = m_oe;
      pdm_clk = ~lr_sel;
      repeat (2) @(negedge clk);
      chk("oe_before_rel", pdm_data_oe, was_oe);
      @(negedge clk);
      m_oe = 1'b0;
      chk("oe_after_rel", pdm_data_oe, 0);
      chk("pdm_hold", pdm_data, m_prev);
      chk("underflow", underflow, m_uf);
      chk("fifo_level", fifo_level, m_fifo.size());
      if (feed && feed_left > 0 && m_fifo.size() < 4) begin
         chk("pcm_ready", pcm_ready, 1);
         push_one(feed_val, acc);
         feed_left--;
      end else @(negedge clk);
   endtask

   task automatic run_const(input shortint v, input int lo, input int hi, input string tag);
      bit acc;
      enable = 1'b0;
      @(negedge clk);
      m_clear();
      osr = 8'd64;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) push_one(v, acc);
      feed_val = v;
      feed_left = 13;
      enable = 1'b1;
      m_state = 1;
      repeat (3) @(negedge clk);
      ones = 0; run_len = 0; max_run = 0; last_obs = 0;
      for (int i = 0; i < 1025; i++) begin
         upd_half();
         rel_half(1'b1);
      end
      chk({tag, "_ones_in_range"}, (ones >= lo && ones <= hi), 1);
   endtask

   initial begin
      bit acc;
      int nacc;
      m_clear();
      repeat (3) @(negedge clk);
      chk("rst_pdm_data", pdm_data, 0);
      chk("rst_oe", pdm_data_oe, 0);
      chk("rst_underflow", underflow, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ready", pcm_ready, 1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // FIFO fill in IDLE: six back-to-back offers, four fit
      nacc = 0;
      for (int i = 0; i < 6; i++) begin
         push_one(shortint'(4096 * (i + 1)), acc);
         nacc += int'(acc);
      end
      chk("fill_accepted", nacc, 4);
      chk("fill_ready", pcm_ready, 0);
      chk("fill_level", fifo_level, 4);
      enable = 1'b1;
      m_state = 1;
      repeat (3) @(negedge clk);
      upd_half();
      chk("pop_level", fifo_level, 3);
      chk("pop_ready", pcm_ready, 1);
      rel_half(1'b0);

      // Left channel: update on fall, release on rise
      for (int i = 0; i < 6; i++) begin
         upd_half();
         rel_half(1'b0);
      end

      // Right channel: update on rise, release on fall
      enable = 1'b0;
      @(negedge clk);
      m_clear();
      chk("disable_level", fifo_level, 0);
      lr_sel = 1'b1;
      pdm_clk = 1'b0;
      repeat (3) @(negedge clk);
      push_one(16'sh3000, acc);
      push_one(16'sh3000, acc);
      enable = 1'b1;
      m_state = 1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 7; i++) begin
         upd_half();
         rel_half(1'b0);
      end

      // Reset while driving a one onto the line
      upd_half();
      for (int i = 0; i < 8 && !m_prev; i++) begin
         rel_half(1'b0);
         upd_half();
      end
      chk("pre_rst_bit", pdm_data, m_prev);
      chk("pre_rst_oe", pdm_data_oe, 1);
      chk("pre_rst_level", fifo_level, m_fifo.size());
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_pdm_data", pdm_data, 0);
      chk("mid_rst_oe", pdm_data_oe, 0);
      chk("mid_rst_level", fifo_level, 0);
      chk("mid_rst_ready", pcm_ready, 1);
      m_clear();
      m_state = 1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      rel_half(1'b0);
      upd_half();
      rel_half(1'b0);

      // Constant inputs over 1024 modulated bits
      lr_sel = 1'b0;
      pdm_clk = 1'b1;
      run_const(16'sh0000, 510, 514, "zero");
      chk("zero_max_run_le2", (max_run <= 2), 1);
      run_const(16'sh4000, 764, 772, "half_pos");
      run_const(-16'sh4000, 252, 260, "half_neg");

      // Underflow: osr=4, two samples, then starve
      enable = 1'b0;
      @(negedge clk);
      m_clear();
      osr = 8'd4;
      repeat (3) @(negedge clk);
      push_one(16'sh2000, acc);
      push_one(-16'sh2000, acc);
      enable = 1'b1;
      m_state = 1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 13; i++) begin
         upd_half();
         rel_half(1'b0);
      end
      chk("uf_set", underflow, 1);
      push_one(16'sh1234, acc);
      chk("uf_level", fifo_level, 1);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      m_clear();
      chk("off_underflow", underflow, 0);
      chk("off_level", fifo_level, 0);
      chk("off_oe", pdm_data_oe, 0);
      chk("off_pdm_data", pdm_data, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
